// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative restoring divider for MIPS DIV/DIVU.
// Produces the quotient (LO) and remainder (HI) one bit per cycle, MSB first.
// A 5-bit index selects the dividend bit that is shifted in, and a one-hot
// decode of the same index sets the matching quotient bit.
// Optional build macro DIV_ITER_EARLY_START_EN: start the index at the MSB of
// |dividend| so that small dividends finish early. Results do not change.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;      // magnitudes of the operands
    logic [WIDTH-1:0] r_q;           // partial remainder (always < b, so fits)
    logic [WIDTH-1:0] q_q;           // unsigned quotient under construction
    logic [IDX_W-1:0] k_q;           // current bit index
    logic             sign_q_q;      // negate the quotient at the end
    logic             sign_r_q;      // negate the remainder at the end
    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    // Operand magnitudes and signs seen at acceptance
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [IDX_W-1:0] k_start;

    // Per-iteration datapath
    logic [WIDTH:0]   t_d;
    logic             ge_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] onehot_d;
    logic [WIDTH-1:0] r_d, q_d;

    // Absolute values of the operands for the unsigned core
    always_comb begin
        neg_a = is_signed_i & dividend_i[WIDTH-1];
        neg_b = is_signed_i & divisor_i[WIDTH-1];
        abs_a = neg_a ? -dividend_i : dividend_i;
        abs_b = neg_b ? -divisor_i  : divisor_i;
    end

`ifdef DIV_ITER_EARLY_START_EN
    // Priority encoder: index of the highest set bit of |dividend| (0 if none)
    always_comb begin
        k_start = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_a[i]) k_start = IDX_W'(i);
        end
    end
`else
    // Fixed start index: always run all WIDTH iterations
    always_comb begin
        k_start = IDX_W'(WIDTH - 1);
    end
`endif

    // One restoring step: shift in a[k], subtract b if it fits, set q[k]
    always_comb begin
        t_d      = {r_q, a_q[k_q]};
        ge_d     = (t_d >= {1'b0, b_q});
        // Low bits of t - b; the upper bit is zero whenever ge_d holds
        diff_d   = t_d[WIDTH-1:0] - b_q;
        onehot_d = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;
        r_d      = ge_d ? diff_d : t_d[WIDTH-1:0];
        q_d      = ge_d ? (q_q | onehot_d) : q_q;
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            k_q      <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            quot_q   <= '0;
            rem_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q      <= abs_a;
                        b_q      <= abs_b;
                        r_q      <= '0;
                        q_q      <= '0;
                        k_q      <= k_start;
                        sign_q_q <= neg_a ^ neg_b;
                        sign_r_q <= neg_a;
                        if (divisor_i == '0) begin
                            // Divide by zero skips the iterations entirely
                            quot_q  <= '1;
                            rem_q   <= dividend_i;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (k_q == '0) begin
                        // Last step: fix up signs from the freshly computed values
                        quot_q  <= sign_q_q ? -q_d : q_d;
                        rem_q   <= sign_r_q ? -r_d : r_d;
                        dbz_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Iterative restoring divider for MIPS DIV/DIVU; produces quotient (LO) and remainder (HI).
- Works opposite to a leading-one priority encoder: each cycle a 5-bit bit index is decoded into a one-hot mask that sets one quotient bit.
- Sits beside the ALU and is driven by the multi-cycle control FSM through a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported for MIPS.
- IDX_W, 5, width of the bit-index counter, equal to log2(WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a divide; sampled only in IDLE.
- is_signed  in  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  in  32  numerator, sampled when start is accepted.
- divisor  in  32  denominator, sampled when start is accepted.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse while in FIN.
- quotient  out  32  result for LO; held until the next accepted start.
- remainder  out  32  result for HI; held until the next accepted start.
- div_by_zero  out  1  flag for the last operation; held with the results.

Behaviour:
- Reset (asynchronous, any state): state = IDLE. busy, done, quotient, remainder, div_by_zero all = 0.
- States: IDLE, RUN, FIN.
- IDLE, start=1 at edge E0:
  - latch a = |dividend| and b = |divisor|. For DIVU, or for non-negative signed operands, the value is used as is.
  - latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); both are 0 when is_signed=0.
  - k = 31, partial remainder r = 0 (33 bits), internal quotient q = 0.
  - If divisor == 0: go to FIN. Otherwise go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, one iteration per edge:
  - t = {r[31:0], a[k]} (33 bits).
  - If t >= {1'b0, b}: r = t - b and q = q | onehot(k). Otherwise r = t.
  - If k == 0: go to FIN and load the outputs. Otherwise k = k - 1.
- Output load on RUN->FIN:
  - quotient = sign_q ? -q : q.
  - remainder = sign_r ? -r[31:0] : r[31:0].
  - div_by_zero = 0.
- Divide-by-zero path (IDLE->FIN): quotient = 0xFFFFFFFF, remainder = dividend as sampled (raw, not absolute), div_by_zero = 1.
- FIN: done = 1 for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and FIN. No queuing.
- Latency: the start edge E0 is followed by 32 iterations at E1..E32. done is high in the cycle after E32 and falls at E33. Divide-by-zero: done is high in the cycle after E0.
- Signed overflow 0x80000000 / 0xFFFFFFFF: the natural wrap result, quotient = 0x80000000, remainder = 0. No flag.
- Arithmetic: the subtract and compare are 33 bits wide so the shifted remainder cannot overflow. Negation is 32-bit two's complement.
- Operand inputs may change after acceptance without effect.
- Reset during RUN or FIN: abort immediately. No done pulse and all outputs cleared.

Optional Feature:
- Macro: DIV_ITER_EARLY_START_EN.
- When defined:
  - on acceptance, k starts at the index of the most significant set bit of |dividend|, found with an internal priority encoder. k = 0 when the dividend is 0.
  - iterations = k0 + 1, so done comes k0 + 1 cycles after E0.
  - results are identical to the non-optional build.
- When undefined: k always starts at 31 and latency is fixed at 32 iterations.

Test Plan:
- DIVU 100 / 7 -> quotient 14, remainder 2, div_by_zero 0. busy high for 32 cycles, then done for exactly 1 cycle.
- DIV -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- DIVU 0x12345678 / 0 -> done in the cycle after the start edge, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- Assert start again at iteration 10 with new operands -> ignored; the first result completes unchanged. Assert reset at iteration 20 -> all outputs 0 at once, no done pulse, the next start works normally.
- With DIV_ITER_EARLY_START_EN: DIVU 5 / 1 -> done 3 cycles after the start edge, quotient 5, remainder 0. DIVU 0 / 3 -> done after 1 iteration, quotient 0, remainder 0.
